alu_op_sequencer: RTL

- Issuing side of the 16-bit ALU result multiplexer.
- Accepts binary-coded commands over a valid/ready handshake and encodes the opcode into the 12-bit one-hot select the result mux decodes.
- Drives registered operands to the function units, waits a programmable settle time, then captures the muxed result into an accumulator.
- Returns the result on a valid/ready response channel. Sits between the command source (testbench/top-level controller) and the ALU datapath.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_op_sequencer_if.sv | 50 +++++
 rtl/alu_op_encoder.sv | 38 +++
 rtl/alu_op_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU op sequencer and its function-select encoder:
//   - binary opcodes OP_AND..OP_CLEAR (the code is the one-hot bit index)
//   - one-hot select constants SEL_AND..SEL_CLEAR for the result mux
//   - NUM_OPS, the number of legal opcodes (codes 12..15 are illegal)
//   - the sequencer FSM state encoding
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int NUM_OPS = 12;

  localparam logic [3:0] OP_AND     = 4'd0;
  localparam logic [3:0] OP_OR      = 4'd1;
  localparam logic [3:0] OP_NOT     = 4'd2;
  localparam logic [3:0] OP_XOR     = 4'd3;
  localparam logic [3:0] OP_NAND    = 4'd4;
  localparam logic [3:0] OP_NOR     = 4'd5;
  localparam logic [3:0] OP_XNOR    = 4'd6;
  localparam logic [3:0] OP_ADD     = 4'd7;
  localparam logic [3:0] OP_SUB     = 4'd8;
  localparam logic [3:0] OP_SHRIGHT = 4'd9;
  localparam logic [3:0] OP_SHLEFT  = 4'd10;
  localparam logic [3:0] OP_CLEAR   = 4'd11;

  localparam logic [NUM_OPS-1:0] SEL_AND     = 12'h001;
  localparam logic [NUM_OPS-1:0] SEL_OR      = 12'h002;
  localparam logic [NUM_OPS-1:0] SEL_NOT     = 12'h004;
  localparam logic [NUM_OPS-1:0] SEL_XOR     = 12'h008;
  localparam logic [NUM_OPS-1:0] SEL_NAND    = 12'h010;
  localparam logic [NUM_OPS-1:0] SEL_NOR     = 12'h020;
  localparam logic [NUM_OPS-1:0] SEL_XNOR    = 12'h040;
  localparam logic [NUM_OPS-1:0] SEL_ADD     = 12'h080;
  localparam logic [NUM_OPS-1:0] SEL_SUB     = 12'h100;
  localparam logic [NUM_OPS-1:0] SEL_SHRIGHT = 12'h200;
  localparam logic [NUM_OPS-1:0] SEL_SHLEFT  = 12'h400;
  localparam logic [NUM_OPS-1:0] SEL_CLEAR   = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles the sequencer's three channels:
//   command  : cmd_valid/cmd_ready handshake with cmd_op, cmd_src, cmd_a, cmd_b
//   datapath : alu_sel, alu_a, alu_b out to the function units; alu_res,
//              alu_carry back from the result mux
//   response : rsp_valid/rsp_ready handshake with rsp_data, rsp_carry, rsp_err,
//              plus the accumulator value acc
// Modports: slave = the sequencer, master = its environment.
// -----------------------------------------------------------------------------
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 12
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic             cmd_src;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_err;
  logic [WIDTH-1:0] acc;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_a, cmd_b,
    input  alu_res, alu_carry, rsp_ready,
    output cmd_ready, alu_sel, alu_a, alu_b,
    output rsp_valid, rsp_data, rsp_carry, rsp_err, acc
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_a, cmd_b,
    output alu_res, alu_carry, rsp_ready,
    input  cmd_ready, alu_sel, alu_a, alu_b,
    input  rsp_valid, rsp_data, rsp_carry, rsp_err, acc
  );

endinterface

// File: rtl/alu_op_encoder.sv
// -----------------------------------------------------------------------------
// alu_op_encoder
// Combinational binary-opcode to one-hot function-select encoder.
//   i_op    : 4-bit binary opcode
//   o_sel   : NUM_OPS-bit one-hot select (all zero for an illegal code)
//   o_legal : 1 when i_op names one of the NUM_OPS functions
// -----------------------------------------------------------------------------
module alu_op_encoder
  import alu_pkg::*;
(
  input  logic [3:0]         i_op,
  output logic [NUM_OPS-1:0] o_sel,
  output logic               o_legal
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    o_sel   = '0;
    o_legal = 1'b1;
    case (i_op)
      OP_AND:     o_sel = SEL_AND;
      OP_OR:      o_sel = SEL_OR;
      OP_NOT:     o_sel = SEL_NOT;
      OP_XOR:     o_sel = SEL_XOR;
      OP_NAND:    o_sel = SEL_NAND;
      OP_NOR:     o_sel = SEL_NOR;
      OP_XNOR:    o_sel = SEL_XNOR;
      OP_ADD:     o_sel = SEL_ADD;
      OP_SUB:     o_sel = SEL_SUB;
      OP_SHRIGHT: o_sel = SEL_SHRIGHT;
      OP_SHLEFT:  o_sel = SEL_SHLEFT;
      OP_CLEAR:   o_sel = SEL_CLEAR;
      default:    o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Issuing side of the ALU result multiplexer. Accepts a command, registers the
// operands, drives the one-hot function select for SETTLE cycles, captures the
// muxed result into the accumulator and returns it on the response channel.
// Parameters: WIDTH operand width, SEL_W select width, SETTLE hold cycles
//             before capture (legal range 1..15).
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset, aborts any operation in flight
//   bus  : alu_op_sequencer_if.slave (command, datapath and response channels)
// -----------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SEL_W  = 12,
  parameter int SETTLE = 1
) (
  input logic                clk,
  input logic                rst,
  alu_op_sequencer_if.slave  bus
);

  state_e           r_state;
  state_e           w_next_state;
  logic             r_live;
  logic [3:0]       r_op;
  logic [SEL_W-1:0] r_sel;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_carry;
  logic             r_rsp_err;
  logic [WIDTH-1:0] r_acc;

  logic [SEL_W-1:0] w_cmd_sel;
  logic             w_cmd_legal;
  logic             w_cmd_ready;
  logic             w_rsp_valid;
  logic [SEL_W-1:0] w_alu_sel;
  logic             w_accept;
  logic             w_cnt_done;
  logic             w_is_arith;
  logic [WIDTH-1:0] w_result;

  alu_op_encoder u_encoder (
    .i_op    (bus.cmd_op),
    .o_sel   (w_cmd_sel),
    .o_legal (w_cmd_legal)
  );

  assign w_accept   = bus.cmd_valid & w_cmd_ready;
  assign w_cnt_done = (r_cnt == 4'd0);
  assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
  // CLEAR ignores whatever the mux presents.
  assign w_result   = (r_op == OP_CLEAR) ? '0 : bus.alu_res;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Holds cmd_ready low until the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_live <= 1'b0;
    else     r_live <= 1'b1;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)      w_next_state = w_cmd_legal ? ST_ISSUE : ST_RESP;
      ST_ISSUE: if (w_cnt_done)    w_next_state = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) w_next_state = ST_IDLE;
      default:                     w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_cmd_ready = 1'b0;
    w_alu_sel   = '0;
    w_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE:  w_cmd_ready = r_live;
      ST_ISSUE: w_alu_sel   = r_sel;
      ST_RESP:  w_rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Operand, counter, response and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register is reset, including the internal op copy, so an
    // aborted operation leaves nothing behind.
    if (rst) begin
      r_op        <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_acc       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.cmd_op;
            r_sel   <= w_cmd_sel;
            r_cnt   <= 4'(SETTLE - 1);
            // acc as of the accept edge, i.e. the previous result.
            r_alu_a <= bus.cmd_src ? r_acc : bus.cmd_a;
            r_alu_b <= bus.cmd_b;
            if (!w_cmd_legal) begin
              r_rsp_data  <= r_acc;
              r_rsp_carry <= 1'b0;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (w_cnt_done) begin
            r_rsp_data  <= w_result;
            r_acc       <= w_result;
            r_rsp_carry <= w_is_arith ? bus.alu_carry : 1'b0;
            r_rsp_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.alu_sel   = w_alu_sel;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.acc       = r_acc;

endmodule
